// File: rtl/stack_cpu_pkg.sv
// Shared types for the 8-bit stack CPU control unit: opcodes, ALU codes,
// controller state encoding and the control word driven into DataPath.
package stack_cpu_pkg;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_NOT  = 3'b011;
  localparam logic [2:0] OPC_PUSH = 3'b100;
  localparam logic [2:0] OPC_POP  = 3'b101;
  localparam logic [2:0] OPC_JMP  = 3'b110;
  localparam logic [2:0] OPC_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_POPA, S_POPB, S_ALU, S_PUSHR,
    S_MRD, S_PUSHM, S_MWR, S_JMP, S_TOS, S_JZ
  } ctrl_state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       m_to_s;
    logic       ld_a;
    logic       ld_b;
    logic       src_a;
    logic       src_b;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational state -> control-word decoder. The only opcode dependence
// is the ALU operation, which follows opcode[1:0] directly.
module stack_ctrl_decode
  import stack_cpu_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  ctrl_state_t      state,
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.src_a    = 1'b1;
        ctrl.src_b    = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.pc_write = 1'b1;
      end
      S_ID:  ctrl.tos = 1'b1;
      S_POPA: begin
        ctrl.pop  = 1'b1;
        ctrl.ld_a = 1'b1;
      end
      S_POPB: begin
        ctrl.pop  = 1'b1;
        ctrl.ld_b = 1'b1;
      end
      S_ALU:   ctrl.alu_op = opcode[1:0];
      S_PUSHR: ctrl.push = 1'b1;
      S_MRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_PUSHM: begin
        ctrl.push   = 1'b1;
        ctrl.m_to_s = 1'b1;
      end
      S_MWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = 1'b1;
      end
      S_TOS: ctrl.tos = 1'b1;
      // Conditional branch; the operand stays on the stack.
      S_JZ: begin
        ctrl.pc_src        = 1'b1;
        ctrl.pc_write_cond = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/stack_controller.sv
// Multicycle Moore control unit for the stack CPU. Optional retired-
// instruction counter instr_count is built when CTRL_PERF_EN is defined.
module stack_controller
  import stack_cpu_pkg::*;
#(
  parameter int OPC_W = 3
`ifdef CTRL_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IrWrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] AluOp
`ifdef CTRL_PERF_EN
  , output logic [CNT_W-1:0] instr_count
`endif
);

  ctrl_state_t      state_q, state_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  ctrl_word_t       ctrl;
  logic             unused_inst;

  assign unused_inst = ^inst[7-OPC_W:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RST;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    unique case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        opcode_d = inst[7 -: OPC_W];
        state_d  = S_ID;
      end
      S_ID: begin
        unique case (opcode_q)
          OPC_PUSH: state_d = S_MRD;
          OPC_JMP:  state_d = S_JMP;
          OPC_JZ:   state_d = S_TOS;
          default:  state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        unique case (opcode_q)
          OPC_NOT: state_d = S_ALU;
          OPC_POP: state_d = S_MWR;
          default: state_d = S_POPB;
        endcase
      end
      S_POPB:  state_d = S_ALU;
      S_ALU:   state_d = S_PUSHR;
      S_MRD:   state_d = S_PUSHM;
      S_TOS:   state_d = S_JZ;
      S_PUSHR, S_PUSHM, S_MWR, S_JMP, S_JZ: state_d = S_IF;
      default: state_d = S_RST;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The fetch that follows reset is not a retirement.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_IF && state_q != S_RST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

  stack_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .state  (state_q),
    .opcode (opcode_q),
    .ctrl   (ctrl)
  );

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign pcSrc       = ctrl.pc_src;
  assign IorD        = ctrl.i_or_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign IrWrite     = ctrl.ir_write;
  assign MtoS        = ctrl.m_to_s;
  assign ldA         = ctrl.ld_a;
  assign ldB         = ctrl.ld_b;
  assign srcA        = ctrl.src_a;
  assign srcB        = ctrl.src_b;
  assign push        = ctrl.push;
  assign pop         = ctrl.pop;
  assign tos         = ctrl.tos;
  assign AluOp       = ctrl.alu_op;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: directed vector table, reset
// sequences and randomized instruction streams against a sequence model.
module tb_stack_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inst;
  logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS;
  logic ldA, ldB, srcA, srcB, push, pop, tos;
  logic [1:0] AluOp;
`ifdef CTRL_PERF_EN
  logic [3:0] instr_count;
`endif

  always #5 clk = ~clk;

  stack_controller #(
    .OPC_W(3)
`ifdef CTRL_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .inst(inst),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IrWrite(IrWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
    .push(push), .pop(pop), .tos(tos), .AluOp(AluOp)
`ifdef CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  // Control word bit positions in the bench's packed view of the outputs.
  localparam logic [16:0] K_PCW   = 17'h10000, K_PCWC = 17'h08000, K_PCSRC = 17'h04000;
  localparam logic [16:0] K_IORD  = 17'h02000, K_MRD  = 17'h01000, K_MWR   = 17'h00800;
  localparam logic [16:0] K_IRW   = 17'h00400, K_MTOS = 17'h00200, K_LDA   = 17'h00100;
  localparam logic [16:0] K_LDB   = 17'h00080, K_SRCA = 17'h00040, K_SRCB  = 17'h00020;
  localparam logic [16:0] K_PUSH  = 17'h00010, K_POP  = 17'h00008, K_TOS   = 17'h00004;
  localparam logic [16:0] K_ZERO  = 17'h00000;
  localparam logic [16:0] K_IF    = K_MRD | K_IRW | K_SRCA | K_SRCB | K_PCW;

  typedef struct {
    logic [7:0]  inst;
    int          lat;
    int          idx;
    logic [16:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  int  cnt_model;
  bit  after_rst;

  function automatic logic [16:0] word();
    return {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS,
            ldA, ldB, srcA, srcB, push, pop, tos, AluOp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words after IF, taken straight from the per-opcode step lists.
  task automatic build_tail(input logic [2:0] opc);
    exp_q.push_back(K_TOS);
    case (opc)
      3'd0, 3'd1, 3'd2: begin
        exp_q.push_back(K_POP | K_LDA);
        exp_q.push_back(K_POP | K_LDB);
        exp_q.push_back({15'd0, opc[1:0]});
        exp_q.push_back(K_PUSH);
      end
      3'd3: begin
        exp_q.push_back(K_POP | K_LDA);
        exp_q.push_back(17'd3);
        exp_q.push_back(K_PUSH);
      end
      3'd4: begin
        exp_q.push_back(K_IORD | K_MRD);
        exp_q.push_back(K_PUSH | K_MTOS);
      end
      3'd5: begin
        exp_q.push_back(K_POP | K_LDA);
        exp_q.push_back(K_IORD | K_MWR);
      end
      3'd6: exp_q.push_back(K_PCSRC | K_PCW);
      default: begin
        exp_q.push_back(K_TOS);
        exp_q.push_back(K_PCSRC | K_PCWC);
      end
    endcase
  endtask

  // Leaves the bench at a falling edge inside the single post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    inst = 8'h00;
    @(negedge clk);
    chk("reset_outputs", {15'd0, word()}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cycle", {15'd0, word()}, 32'd0);
  endtask

  task automatic wait_if(output bit ok);
    int n = 0;
    while (!IrWrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = IrWrite;
    if (!ok) chk("wait_if_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int cyc = 0;
    logic [16:0] got = 'x;
    wait_if(ok);
    if (!ok) return;
    inst = v.inst;
    do begin
      @(negedge clk);
      cyc++;
      inst = ~v.inst;
      if (cyc == v.idx) got = word();
    end while (!IrWrite && cyc < 20);
    chk($sformatf("latency_%02h", v.inst), cyc, v.lat);
    chk($sformatf("word_%02h_c%0d", v.inst, v.idx), {15'd0, got}, {15'd0, v.exp});
  endtask

  vec_t vecs[$];

  initial begin
    bit ok;
    rst = 1'b1;
    inst = 8'h00;

    vecs.push_back('{8'h83, 4, 2, K_IORD | K_MRD});
    vecs.push_back('{8'h83, 4, 3, K_PUSH | K_MTOS});
    vecs.push_back('{8'h20, 6, 2, K_POP | K_LDA});
    vecs.push_back('{8'h20, 6, 3, K_POP | K_LDB});
    vecs.push_back('{8'h20, 6, 4, 17'd1});
    vecs.push_back('{8'h20, 6, 5, K_PUSH});
    vecs.push_back('{8'hE9, 4, 2, K_TOS});
    vecs.push_back('{8'hE9, 4, 3, K_PCSRC | K_PCWC});
    vecs.push_back('{8'hA4, 4, 2, K_POP | K_LDA});
    vecs.push_back('{8'hA4, 4, 3, K_IORD | K_MWR});
    vecs.push_back('{8'hC2, 3, 2, K_PCSRC | K_PCW});
    vecs.push_back('{8'h60, 5, 3, 17'd3});
    vecs.push_back('{8'h5F, 6, 4, 17'd2});
    vecs.push_back('{8'h1F, 6, 1, K_TOS});

    do_reset();
    @(negedge clk);
    chk("first_fetch", {15'd0, word()}, {15'd0, K_IF});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset held three cycles in the middle of an ADD.
    wait_if(ok);
    inst = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_async_mid_add", {15'd0, word()}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_mid_add", {15'd0, word()}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", {15'd0, word()}, 32'd0);
    @(negedge clk);
    chk("rst_release_fetch", {15'd0, word()}, {15'd0, K_IF});
`ifdef CTRL_PERF_EN
    chk("count_after_reset", {28'd0, instr_count}, 32'd0);
    for (int i = 0; i < 17; i++) run_vec('{8'h60, 5, 3, 17'd3});
    chk("count_wrap_17_not", {28'd0, instr_count}, 32'd1);
`endif

    // Random instruction stream with occasional resets.
    do_reset();
    exp_q.delete();
    after_rst = 1'b1;
    cnt_model = 0;
    for (int it = 0; it < 800; it++) begin
      logic [16:0] e, w;
      @(negedge clk);
      w = word();
      if (exp_q.size() == 0) begin
        e = K_IF;
        build_tail(inst[7:5]);
        if (!after_rst) cnt_model = (cnt_model + 1) % 16;
        after_rst = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      chk("rand_word", {15'd0, w}, {15'd0, e});
      chk("push_pop_excl", {31'd0, push & pop}, 32'd0);
      chk("mem_rw_excl", {31'd0, memRead & memWrite}, 32'd0);
      chk("pcw_excl", {31'd0, pcWrite & pcWriteCond}, 32'd0);
`ifdef CTRL_PERF_EN
      chk("rand_count", {28'd0, instr_count}, cnt_model);
`endif
      @(posedge clk);
      #1;
      inst = 8'($urandom);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(K_ZERO);
        exp_q.push_back(K_ZERO);
        after_rst = 1'b1;
        cnt_model = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
